// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point rescaler: intermediate
// widths, saturation bounds and the per-beat sideband record.
package bfp_pkg;

  typedef struct packed {
    logic last;
  } bfp_side_t;

  // Width that holds the largest left shift without losing bits.
  function automatic int bfp_lshift_w(int in_w, int shift_w, int shift_target);
    return in_w + (1 << shift_w) - shift_target;
  endfunction

  // One guard bit so the rounding increment cannot overflow.
  function automatic int bfp_rshift_w(int in_w);
    return in_w + 1;
  endfunction

  // Stage-1 register width: wide enough for either shift direction.
  function automatic int bfp_wide_w(int in_w, int shift_w, int shift_target);
    int lw;
    int rw;
    lw = bfp_lshift_w(in_w, shift_w, shift_target);
    rw = bfp_rshift_w(in_w);
    return (lw > rw) ? lw : rw;
  endfunction

  function automatic longint bfp_sat_hi(int out_w);
    return (longint'(1) << (out_w - 1)) - 1;
  endfunction

  function automatic longint bfp_sat_lo(int out_w);
    return -(longint'(1) << (out_w - 1));
  endfunction

endpackage

// File: rtl/bfp_lane_scale.sv
// One lane of the rescaler, purely combinational. The shift/round half
// feeds the stage-1 register; the saturate half works on the stage-1
// register output, so the two halves have independent ports.
module bfp_lane_scale
  import bfp_pkg::*;
#(
  parameter int IN_W         = 23,
  parameter int OUT_W        = 11,
  parameter int SHIFT_W      = 5,
  parameter int SHIFT_TARGET = 12,
  parameter bit ROUND_EN     = 1'b1,
  parameter int WIDE_W       = bfp_wide_w(IN_W, SHIFT_W, SHIFT_TARGET)
) (
  input  logic [IN_W-1:0]    i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [WIDE_W-1:0]  o_wide,
  input  logic [WIDE_W-1:0]  i_wide,
  output logic [OUT_W-1:0]   o_y,
  output logic               o_sat
);

  localparam int RW = bfp_rshift_w(IN_W);
  localparam logic signed [WIDE_W-1:0] SAT_HI = WIDE_W'(bfp_sat_hi(OUT_W));
  localparam logic signed [WIDE_W-1:0] SAT_LO = WIDE_W'(bfp_sat_lo(OUT_W));

  int                       w_d;
  int                       w_k;
  logic signed [RW-1:0]     w_rx;
  logic signed [WIDE_W-1:0] w_v;

  // Exponent relative to unity gain selects right shift (with optional
  // round-half-up) or lossless left shift.
  always_comb begin
    w_d    = int'(i_shift) - SHIFT_TARGET;
    w_k    = 0;
    w_rx   = RW'($signed(i_x));
    o_wide = '0;
    if (w_d < 0) begin
      w_k = -w_d;
      if (ROUND_EN) begin
        w_rx = w_rx + (RW'(1) << (w_k - 1));
      end
      o_wide = WIDE_W'(w_rx >>> w_k);
    end else begin
      o_wide = WIDE_W'($signed(i_x)) << w_d;
    end
  end

  assign w_v = $signed(i_wide);

  // Clip the full-precision value into the signed output range.
  always_comb begin
    o_sat = 1'b0;
    o_y   = w_v[OUT_W-1:0];
    if (w_v > SAT_HI) begin
      o_y   = SAT_HI[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (w_v < SAT_LO) begin
      o_y   = SAT_LO[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/bfp_rescale_pipe.sv
// Two-stage elastic rescaler: S1 holds the shifted wide lanes, S2 the
// saturated lanes and flags. A per-block saturation counter rides on the
// output handshake and clears after the beat flagged last.
module bfp_rescale_pipe
  import bfp_pkg::*;
#(
  parameter int IN_W         = 23,
  parameter int OUT_W        = 11,
  parameter int SHIFT_W      = 5,
  parameter int SHIFT_TARGET = 12,
  parameter int LANES        = 2,
  parameter bit ROUND_EN     = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic                   out_last,
  output logic [CNT_W-1:0]       out_blk_sat_cnt
);

  localparam int WIDE_W = bfp_wide_w(IN_W, SHIFT_W, SHIFT_TARGET);

  logic                     r_s1_valid;
  logic [LANES*WIDE_W-1:0]  r_s1_wide;
  bfp_side_t                r_s1_side;
  logic                     r_s2_valid;
  logic [LANES*OUT_W-1:0]   r_s2_data;
  logic [LANES-1:0]         r_s2_sat;
  bfp_side_t                r_s2_side;
  logic [CNT_W-1:0]         r_cnt;

  logic                     w_s1_move;
  logic                     w_out_fire;
  logic [LANES*WIDE_W-1:0]  w_wide;
  logic [LANES*OUT_W-1:0]   w_y;
  logic [LANES-1:0]         w_sat;
  logic [CNT_W:0]           w_sum;
  logic [CNT_W-1:0]         w_cnt_now;

  assign w_s1_move  = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s1_move;
  assign w_out_fire = r_s2_valid && out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bfp_lane_scale #(
      .IN_W         (IN_W),
      .OUT_W        (OUT_W),
      .SHIFT_W      (SHIFT_W),
      .SHIFT_TARGET (SHIFT_TARGET),
      .ROUND_EN     (ROUND_EN),
      .WIDE_W       (WIDE_W)
    ) u_lane (
      .i_x     (in_data[g*IN_W +: IN_W]),
      .i_shift (in_shift),
      .o_wide  (w_wide[g*WIDE_W +: WIDE_W]),
      .i_wide  (r_s1_wide[g*WIDE_W +: WIDE_W]),
      .o_y     (w_y[g*OUT_W +: OUT_W]),
      .o_sat   (w_sat[g])
    );
  end

  // S1: capture shifted lanes whenever the stage is free or draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_wide  <= '0;
      r_s1_side  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_wide      <= w_wide;
        r_s1_side.last <= in_last;
      end
    end
  end

  // S2: capture saturated lanes; held stable while the output stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= '0;
      r_s2_side  <= '0;
    end else if (w_s1_move) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_y;
        r_s2_sat  <= w_sat;
        r_s2_side <= r_s1_side;
      end
    end
  end

  // Running block total including the beat currently on the output.
  always_comb begin
    w_sum = {1'b0, r_cnt};
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + (CNT_W+1)'(r_s2_sat[i]);
    end
    w_cnt_now = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // Accumulate on each output handshake; the last beat restarts the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= r_s2_side.last ? '0 : w_cnt_now;
    end
  end

  assign out_valid       = r_s2_valid;
  assign out_data        = r_s2_data;
  assign out_sat         = r_s2_sat;
  assign out_last        = r_s2_side.last;
  assign out_blk_sat_cnt = w_cnt_now;

endmodule

// File: tb/tb_bfp_rescale_pipe.sv
// Bench for bfp_rescale_pipe: directed beats from the test plan followed by
// randomized traffic and backpressure, checked against an arithmetic model.
module tb_bfp_rescale_pipe;

  localparam int IN_W = 23;
  localparam int OUT_W = 11;
  localparam int SHIFT_W = 5;
  localparam int LANES = 2;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [SHIFT_W-1:0]     in_shift;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;
  logic                   out_last;
  logic [CNT_W-1:0]       out_blk_sat_cnt;

  logic                   fl_in_ready;
  logic                   fl_out_valid;
  logic [LANES*OUT_W-1:0] fl_out_data;
  logic [LANES-1:0]       fl_out_sat;
  logic                   fl_out_last;
  logic [CNT_W-1:0]       fl_cnt;

  always #5 clk = ~clk;

  bfp_rescale_pipe #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_last(out_last), .out_blk_sat_cnt(out_blk_sat_cnt)
  );

  bfp_rescale_pipe #(.ROUND_EN(1'b0)) dut_fl (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fl_in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_last(in_last),
    .out_valid(fl_out_valid), .out_ready(out_ready), .out_data(fl_out_data),
    .out_sat(fl_out_sat), .out_last(fl_out_last), .out_blk_sat_cnt(fl_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Ideal rescale: multiply by 2^(shift-12), round or floor, then clip.
  function automatic longint model(input longint x, input int sh, input bit rnd, output bit sat);
    longint v;
    longint p;
    int d;
    d = sh - 12;
    if (d < 0) begin
      p = longint'(1) << (-d);
      v = rnd ? floor_div(x + p / 2, p) : floor_div(x, p);
    end else begin
      v = x * (longint'(1) << d);
    end
    sat = 1'b0;
    if (v > 1023) begin v = 1023; sat = 1'b1; end
    if (v < -1024) begin v = -1024; sat = 1'b1; end
    return v;
  endfunction

  typedef struct {
    longint yr0, yr1, yf0, yf1;
    bit     s0, s1;
    bit     last;
    int     acc;
  } exp_t;

  exp_t   q[$];
  int     blk_hist[$];
  int     win = 0;
  longint mcnt = 0;
  bit     post_rst = 1'b0;
  int     stalled_full = 0;

  function automatic longint lane(input logic [LANES*OUT_W-1:0] v, input int i);
    logic [OUT_W-1:0] t;
    t = v[i*OUT_W +: OUT_W];
    return longint'($signed(t));
  endfunction

  function automatic longint in_lane(input logic [LANES*IN_W-1:0] v, input int i);
    logic [IN_W-1:0] t;
    t = v[i*IN_W +: IN_W];
    return longint'($signed(t));
  endfunction

  // Single compare process: sampled between edges, after inputs settle.
  always @(negedge clk) begin
    exp_t   e;
    exp_t   h;
    longint pops;
    longint ecnt;
    #2;
    win++;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_cnt", longint'(out_blk_sat_cnt), 0);
        post_rst = 1'b0;
      end
      chk("in_ready", longint'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
      if (q.size() == 2 && !out_ready) stalled_full++;
      chk("out_valid", longint'(out_valid), (q.size() > 0 && win - q[0].acc >= 2) ? 1 : 0);
      chk("fl_out_valid", longint'(fl_out_valid), longint'(out_valid));
      if (out_valid && q.size() > 0) begin
        h = q[0];
        chk("lane0", lane(out_data, 0), h.yr0);
        chk("lane1", lane(out_data, 1), h.yr1);
        chk("fl_lane0", lane(fl_out_data, 0), h.yf0);
        chk("fl_lane1", lane(fl_out_data, 1), h.yf1);
        chk("sat", longint'(out_sat), longint'({h.s1, h.s0}));
        chk("last", longint'(out_last), longint'(h.last));
        pops = longint'(h.s0) + longint'(h.s1);
        ecnt = (mcnt + pops > 65535) ? 65535 : mcnt + pops;
        if (h.last) chk("blk_cnt", longint'(out_blk_sat_cnt), ecnt);
        if (out_ready) begin
          if (h.last) begin
            blk_hist.push_back(int'(out_blk_sat_cnt));
            mcnt = 0;
          end else begin
            mcnt = ecnt;
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e.yr0 = model(in_lane(in_data, 0), int'(in_shift), 1'b1, e.s0);
        e.yr1 = model(in_lane(in_data, 1), int'(in_shift), 1'b1, e.s1);
        e.yf0 = model(in_lane(in_data, 0), int'(in_shift), 1'b0, h.s0);
        e.yf1 = model(in_lane(in_data, 1), int'(in_shift), 1'b0, h.s1);
        e.last = in_last;
        e.acc = win;
        q.push_back(e);
      end
    end
  end

  int dcyc = 0;
  bit rnd_mode = 1'b0;
  int stall_lo = -1;
  int stall_hi = -1;

  task automatic tick();
    @(negedge clk);
    dcyc++;
    if (rnd_mode) out_ready = ($urandom_range(0, 9) < 7);
    else out_ready = !(dcyc >= stall_lo && dcyc <= stall_hi);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input longint x0, input longint x1, input int sh, input bit last);
    int t;
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    a = IN_W'(x0);
    b = IN_W'(x1);
    t = 0;
    forever begin
      tick();
      in_valid = 1'b1;
      in_data  = {b, a};
      in_shift = SHIFT_W'(sh);
      in_last  = last;
      #1;
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  function automatic longint rnd_x();
    logic [IN_W-1:0] t;
    if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 8191)) - 4096;
    t = IN_W'($urandom);
    return longint'($signed(t));
  endfunction

  initial begin
    bit s;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_shift = '0;
    in_last = 1'b0;
    out_ready = 1'b1;

    chk("model_unity", model(500, 12, 1'b1, s), 500);
    chk("model_rnd_p", model(7, 10, 1'b1, s), 2);
    chk("model_rnd_n", model(-6, 10, 1'b1, s), -1);
    chk("model_flr_p", model(7, 10, 1'b0, s), 1);
    chk("model_flr_n", model(-6, 10, 1'b0, s), -2);
    chk("model_sat_hi", model(300, 14, 1'b1, s), 1023);
    chk("model_sat_lo", model(-2000, 14, 1'b1, s), -1024);
    chk("model_sat31", model(1, 31, 1'b1, s), 1023);
    chk("model_sat31_flag", longint'(s), 1);

    idle(3);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;

    // 4-beat block with 3 saturated lanes, then a 2-beat block with none.
    send(500, -500, 12, 1'b0);
    send(7, -6, 10, 1'b0);
    send(300, -2000, 14, 1'b0);
    send(0, 1, 31, 1'b1);
    send(10, 20, 12, 1'b0);
    send(-5, 5, 12, 1'b1);
    idle(8);
    chk("blk_count_n", longint'(blk_hist.size()), 2);
    if (blk_hist.size() >= 2) begin
      chk("blk0_sat_cnt", longint'(blk_hist[0]), 3);
      chk("blk1_sat_cnt", longint'(blk_hist[1]), 0);
    end

    // Backpressure: output stalls for 4 cycles while 6 beats stream in.
    stall_lo = dcyc + 3;
    stall_hi = dcyc + 6;
    for (int i = 0; i < 6; i++) send(100 * i - 250, 1000 - 37 * i, 11 + (i % 3), i == 5);
    idle(10);
    chk("bp_full_seen", longint'(stalled_full > 0), 1);

    // Reset with two beats held in the pipeline.
    stall_lo = dcyc + 1;
    stall_hi = dcyc + 1000000;
    send(300, 300, 14, 1'b0);
    send(-300, 5, 14, 1'b0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(2);
    stall_lo = -1;
    stall_hi = -1;
    send(300, 0, 14, 1'b1);
    idle(6);
    if (blk_hist.size() > 0) chk("post_rst_blk_cnt", longint'(blk_hist[blk_hist.size()-1]), 1);
    else chk("post_rst_blk_seen", 0, 1);

    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(rnd_x(), rnd_x(), int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
      else
        idle(1);
    end
    rnd_mode = 1'b0;
    idle(12);
    chk("drain_empty", longint'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bfp_rescale_pipe.md
# bfp_rescale_pipe

Pipelined, multi-lane block-floating-point rescaler for the FFT datapath. It converts wide butterfly or accumulator samples to the narrow stage/output format using a per-beat block exponent, with rounding and saturation instead of silent truncation. Valid/ready on both sides, throughput of one beat per cycle. It also counts saturation events per FFT block so the exponent controller can react. Sits between each FFT stage's arithmetic and the inter-stage memory or output port.

## Interface
- IN_W, 23: signed input sample width per lane
- OUT_W, 11: signed output sample width per lane
- SHIFT_W, 5: block exponent width
- SHIFT_TARGET, 12: exponent meaning unity gain
- LANES, 2: parallel lanes per beat (2 = one complex sample, re/im)
- ROUND_EN, 1: 1 = round-half-up on right shifts; 0 = floor (plain arithmetic shift)
- CNT_W, 16: saturation counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], two's complement
- in_shift  in  SHIFT_W  block exponent for this beat, unsigned
- in_last  in  1  final beat of an FFT block
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  rescaled lanes, same packing
- out_sat  out  LANES  per-lane saturation flag for this beat
- out_last  out  1  in_last delayed with its beat
- out_blk_sat_cnt  out  CNT_W  saturated-lane total for the block; meaningful only when out_valid && out_last

## Operation
- Per lane: let d = signed(in_shift) − SHIFT_TARGET.
  - d < 0: k = −d; right-shift by k. If ROUND_EN, add 2^(k−1) before an arithmetic shift. Use IN_W+1 bits so the add cannot overflow.
  - d ≥ 0: left-shift by d. Use width IN_W + 2^SHIFT_W − SHIFT_TARGET so no bits are lost.
- Saturate the full-precision result to OUT_W signed, range [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Set out_sat[i] when clipping occurs.
- Saturation counter:
  - Add popcount(out_sat) on every output handshake.
  - The counter saturates at 2^CNT_W−1.
  - out_blk_sat_cnt is the accumulated value including the current beat.
  - On a handshake with out_last, the counter restarts at 0 for the next beat.
- in_shift, in_last and all lanes travel together. No reordering, no dropping.

## Timing
- Latency is 2 cycles.
  - S1 registers the shifted/rounded wide value plus last.
  - S2 registers the saturated value, sat flags and last.
  - An accepted beat at edge n appears on out_* after edge n+2 when there is no backpressure.
- Elastic pipeline: each stage loads when it is empty or its content is leaving.
  - in_ready = !s1_valid || s1_move, with s1_move = !s2_valid || out_ready.
  - Back-to-back throughput is 1 beat per cycle.
- While out_valid && !out_ready, out_data, out_sat, out_last and out_blk_sat_cnt stay stable.
- A full pipeline with out_ready low holds 2 beats and drops in_ready. When out_ready rises, in_ready rises in the same cycle (combinational path).
- Reset, synchronous on rst_n low at a clk edge:
  - out_valid=0, in_ready=1 after reset, out_data=0, out_sat=0, out_last=0.
  - Saturation counter = 0, s1/s2 valid = 0.
  - A reset mid-block discards in-flight beats and the partial count.
- Simultaneous out_last handshake and new sat on the next beat: the next beat counts from 0.

## Structure
- Shared package bfp_pkg holds:
  - localparam functions for the wide intermediate widths;
  - the saturation bounds helper;
  - typedef for the per-beat sideband struct {last}.
- Sub-module bfp_lane_scale is purely combinational: shift, round and saturate for one lane, outputs the value and a sat flag. Instantiate it LANES times.
  - Split at the S1/S2 boundary: shift/round feeds S1, saturate feeds S2. Either expose two functions or two small modules; bfp_lane_scale wraps both.
- Top level: handshake, pipeline registers, counter.

## Test plan
Defaults throughout: ROUND_EN=1, output range ±1024/1023.
- Unity, shift=12, lanes (500, −500) -> (500, −500), out_sat=00, beat appears 2 cycles after acceptance.
- Rounding, shift=10 (k=2), lanes (7, −6) -> (2, −1). With ROUND_EN=0 -> (1, −2).
- Saturation:
  - shift=14, lanes (300, −2000) -> (1023, −1024), out_sat=11.
  - shift=31, lane 1 -> 2^19 clipped to 1023, sat set.
- Backpressure:
  - Stream 6 beats while out_ready is held low from cycle 3 to 6 -> in_ready low once 2 beats are held.
  - All 6 beats arrive in order with no duplicates, and outputs stay stable while stalled.
- Block count: 4-beat block with 3 saturated lanes total, then a 2-beat block with 0 -> out_blk_sat_cnt=3 on the first out_last, 0 on the second.
- Reset mid-stream: rst_n low for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, in_ready=1, the counter restarts from 0 on the next block.
